// File: rtl/imm_pack_pkg.sv
// Shared encodings for the immediate packer: format selects, error codes, NOP word
// and the FIFO entry layout.
package imm_pack_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_RANGE   = 2'b01,
    ERR_ALIGN   = 2'b10,
    ERR_ILLEGAL = 2'b11
  } err_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    err_e        err;
    logic [31:0] instr;
  } pack_word_t;

  // True when every bit of v selected by mask holds the same value (sign-extension fits).
  function automatic logic bits_uniform(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_pack_fifo.sv
// Synchronous FIFO, head visible the cycle after the first push; push ready is
// count based only, so there is no combinational path from pop to push ready.
module imm_pack_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push_vld,
  output logic         o_push_rdy,
  input  logic [W-1:0] i_push_dat,
  output logic         o_pop_vld,
  input  logic         i_pop_rdy,
  output logic [W-1:0] o_pop_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_push_rdy = (r_cnt < FULL_CNT);
  assign o_pop_vld  = (r_cnt != '0);
  assign w_push     = i_push_vld & o_push_rdy;
  assign w_pop      = i_pop_rdy & o_pop_vld;
  // Empty FIFO presents zeros rather than a stale entry.
  assign o_pop_dat  = o_pop_vld ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/imm_pack_unit.sv
// Validates and packs immediates into RV32I words, buffered in a DEPTH-entry FIFO;
// one cycle accept-to-output when empty, in_ready drops only when the FIFO is full.
module imm_pack_unit
  import imm_pack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] insn_count,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      w_instr;
  err_e             w_err;
  pack_word_t       w_word;
  pack_word_t       w_head;
  logic             w_accept;
  logic [CNT_W-1:0] r_insn_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  // Alignment outranks range; illegal selects bypass both and emit a NOP.
  always_comb begin
    w_instr = NOP;
    w_err   = ERR_NONE;
    case (ImmSrc)
      IMM_I: begin
        w_instr = {imm[11:0], rs1, funct3, rd, opcode};
        if (!bits_uniform(imm, 32'hFFFF_F800)) w_err = ERR_RANGE;
      end
      IMM_S: begin
        w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!bits_uniform(imm, 32'hFFFF_F800)) w_err = ERR_RANGE;
      end
      IMM_B: begin
        w_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (imm[0])                                 w_err = ERR_ALIGN;
        else if (!bits_uniform(imm, 32'hFFFF_F000)) w_err = ERR_RANGE;
      end
      IMM_J: begin
        w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])                                 w_err = ERR_ALIGN;
        else if (!bits_uniform(imm, 32'hFFF0_0000)) w_err = ERR_RANGE;
      end
      IMM_U: begin
        w_instr = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'h000) w_err = ERR_RANGE;
      end
      default: begin
        w_instr = NOP;
        w_err   = ERR_ILLEGAL;
      end
    endcase
  end

  assign w_word   = '{err: w_err, instr: w_instr};
  assign w_accept = in_valid & in_ready;

  imm_pack_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(pack_word_t))
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (in_valid),
    .o_push_rdy (in_ready),
    .i_push_dat (w_word),
    .o_pop_vld  (out_valid),
    .i_pop_rdy  (out_ready),
    .o_pop_dat  (w_head)
  );

  assign out_instr = w_head.instr;
  assign out_err   = w_head.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_insn_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_accept) begin
      if (r_insn_cnt != '1) r_insn_cnt <= r_insn_cnt + CNT_W'(1);
      if ((w_err != ERR_NONE) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign insn_count = r_insn_cnt;
  assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_imm_pack_unit.sv
// Directed plus randomized checks of imm_pack_unit against a decode-based reference model.
module tb_imm_pack_unit;
  import imm_pack_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 6;
  localparam int unsigned MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       opcode = '0;
  logic [4:0]       rd = '0;
  logic [4:0]       rs1 = '0;
  logic [4:0]       rs2 = '0;
  logic [2:0]       funct3 = '0;
  logic [2:0]       ImmSrc = '0;
  logic [31:0]      imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [1:0]       out_err;
  logic [CNT_W-1:0] insn_count;
  logic [CNT_W-1:0] err_count;

  imm_pack_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .ImmSrc(ImmSrc), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .insn_count(insn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
  } req_t;

  req_t        q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int unsigned m_insn = 0;
  int unsigned m_errc = 0;

  function automatic logic [31:0] sx(logic [31:0] v, int n);
    logic signed [31:0] t;
    t = $signed(v << (32 - n));
    return t >>> (32 - n);
  endfunction

  // Value the chosen format can actually carry.
  function automatic logic [31:0] trunc(logic [2:0] src, logic [31:0] v);
    case (src)
      3'd0, 3'd1: return sx(v, 12);
      3'd2:       return sx(v, 13) & ~32'd1;
      3'd3:       return sx(v, 21) & ~32'd1;
      default:    return v & 32'hFFFF_F000;
    endcase
  endfunction

  function automatic logic [1:0] exp_err(req_t r);
    if (r.src > 3'd4) return 2'b11;
    if ((r.src == 3'd2 || r.src == 3'd3) && r.imm[0]) return 2'b10;
    if (trunc(r.src, r.imm) != r.imm) return 2'b01;
    return 2'b00;
  endfunction

  // Immediate extension as the core's decoder performs it.
  function automatic logic [31:0] decode(logic [2:0] src, logic [31:0] w);
    case (src)
      3'd0:    return sx({20'b0, w[31:20]}, 12);
      3'd1:    return sx({20'b0, w[31:25], w[11:7]}, 12);
      3'd2:    return sx({19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
      3'd3:    return sx({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
      default: return {w[31:12], 12'b0};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_head(req_t r);
    logic [1:0] e;
    e = exp_err(r);
    check("head_err", {30'b0, out_err}, {30'b0, e});
    if (e == 2'b11) begin
      check("head_nop", out_instr, NOP);
    end else begin
      check("head_imm", decode(r.src, out_instr), trunc(r.src, r.imm));
      check("head_opcode", {25'b0, out_instr[6:0]}, {25'b0, r.op});
      case (r.src)
        3'd0:       check("head_fields", {14'b0, out_instr[19:7]}, {14'b0, r.rs1, r.f3, r.rd});
        3'd1, 3'd2: check("head_fields", {19'b0, out_instr[24:12]}, {19'b0, r.rs2, r.rs1, r.f3});
        default:    check("head_fields", {27'b0, out_instr[11:7]}, {27'b0, r.rd});
      endcase
    end
  endtask

  task automatic set_req(logic v, logic [2:0] s, logic [31:0] im, logic [6:0] op,
                         logic [4:0] d, logic [4:0] a, logic [4:0] b, logic [2:0] f);
    in_valid = v; ImmSrc = s; imm = im; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f;
  endtask

  task automatic rand_req(logic v);
    logic [2:0]  s;
    logic [31:0] im;
    s = 3'($urandom_range(0, 5));
    if (s == 3'd5) s = 3'($urandom_range(5, 7));
    case ($urandom_range(0, 3))
      0:       im = $urandom;
      1:       im = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       im = $urandom & 32'hFFFF_F000;
      default: im = 32'($urandom_range(0, 4194303)) - 32'd2097152;
    endcase
    set_req(v, s, im, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
  endtask

  // One clock of the model: retire a pop, then record an accept after the edge.
  task automatic cycle();
    bit   acc;
    bit   pop;
    req_t r;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    r = '{ImmSrc, imm, opcode, rd, rs1, rs2, funct3};
    if (pop) begin
      if (q.size() == 0) check("pop_without_entry", {31'b0, out_valid}, 32'd0);
      else begin
        check_head(q[0]);
        void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      q.push_back(r);
      if (m_insn != MAXC) m_insn++;
      if (exp_err(r) != 2'b00 && m_errc != MAXC) m_errc++;
    end
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
  endtask

  task automatic directed(string tag, logic [2:0] s, logic [31:0] im, logic [6:0] op,
                          logic [4:0] d, logic [4:0] a, logic [4:0] b, logic [2:0] f,
                          logic [31:0] exp_instr, logic [1:0] exp_e);
    out_ready = 1'b1;
    set_req(1'b1, s, im, op, d, a, b, f);
    cycle();
    in_valid = 1'b0;
    check(tag, out_instr, exp_instr);
    check({tag, "_err"}, {30'b0, out_err}, {30'b0, exp_e});
    cycle();
  endtask

  task automatic check_counters(string tag);
    check({tag, "_insn_count"}, {26'b0, insn_count}, m_insn);
    check({tag, "_err_count"}, {26'b0, err_count}, m_errc);
  endtask

  initial begin
    int acc;
    int n;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {30'b0, out_err}, 32'd0);
    check_counters("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    directed("i_neg1",   3'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFF1_0093, 2'b00);
    directed("i_2047",   3'd0, 32'h0000_07FF, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h7FF1_0093, 2'b00);
    directed("i_m2048",  3'd0, 32'hFFFF_F800, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h8001_0093, 2'b00);
    directed("i_2048",   3'd0, 32'h0000_0800, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'h8001_0093, 2'b01);
    directed("s_m8",     3'd1, 32'hFFFF_FFF8, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 32'hFE31_2C23, 2'b00);
    directed("b_m4",     3'd2, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFE20_8EE3, 2'b00);
    directed("b_odd",    3'd2, 32'h0000_0003, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0020_8163, 2'b10);
    directed("b_4096",   3'd2, 32'h0000_1000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h8020_8063, 2'b01);
    directed("b_prio",   3'd2, 32'h0000_1001, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h8020_8063, 2'b10);
    directed("j_2048",   3'd3, 32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_00EF, 2'b00);
    directed("j_odd",    3'd3, 32'h0000_0001, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_00EF, 2'b10);
    directed("j_range",  3'd3, 32'h0010_0000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h8000_00EF, 2'b01);
    directed("u_ok",     3'd4, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_52B7, 2'b00);
    directed("u_low",    3'd4, 32'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_52B7, 2'b01);
    directed("illegal6", 3'd6, 32'h0000_0004, 7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 32'h0000_0013, 2'b11);
    check_counters("directed");

    // Backpressure: exactly DEPTH accepts, extra valid cycles while full are ignored.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      rand_req(1'b1);
      if (in_ready) acc++;
      cycle();
    end
    in_valid = 1'b0;
    check("bp_accepts", acc, DEPTH);
    check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4 && q.size() != 0; i++) cycle();
    check("bp_drained", {31'b0, out_valid}, 32'd0);

    // Steady state: two entries in flight, push and pop every cycle.
    out_ready = 1'b0;
    repeat (2) begin rand_req(1'b1); cycle(); end
    out_ready = 1'b1;
    repeat (10) begin rand_req(1'b1); cycle(); end
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && out_valid; i++) begin n++; cycle(); end
    check("steady_occupancy", n, 2);
    check_counters("steady");

    // Asynchronous reset with three entries queued.
    out_ready = 1'b0;
    repeat (3) begin rand_req(1'b1); cycle(); end
    in_valid = 1'b0;
    check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    check("arst_out_err", {30'b0, out_err}, 32'd0);
    q.delete();
    m_insn = 0;
    m_errc = 0;
    check_counters("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);

    // Random round-trip with random backpressure; counters reach saturation.
    for (int i = 0; i < 300; i++) begin
      rand_req($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4 && q.size() != 0; i++) cycle();
    check("final_drained", {31'b0, out_valid}, 32'd0);
    check_counters("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
